// File: rtl/calc_arbiter.sv
// rtl/calc_arbiter.sv - round-robin arbiter sharing one calculator core among NREQ clients
// Sequences IDLE -> ISSUE -> WAIT -> RESP with a watchdog on the core's completion strobe.
module calc_arbiter #(
    parameter int NREQ        = 4,
    parameter int W           = 8,
    parameter int FW          = 2,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic [NREQ-1:0]         req_valid_i,
    input  logic [NREQ*W-1:0]       req_a_i,
    input  logic [NREQ*W-1:0]       req_b_i,
    input  logic [NREQ*FW-1:0]      req_fct_i,
    output logic [NREQ-1:0]         req_ready_o,
    output logic                    calc_start_o,
    output logic [W-1:0]            calc_a_o,
    output logic [W-1:0]            calc_b_o,
    output logic [FW-1:0]           calc_fct_o,
    output logic                    calc_abort_o,
    input  logic                    calc_done_i,
    input  logic [W-1:0]            calc_s_i,
    input  logic                    calc_signal_i,
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output logic [$clog2(NREQ)-1:0] resp_id_o,
    output logic [W-1:0]            resp_s_o,
    output logic                    resp_signal_o,
    output logic                    resp_err_o,
    output logic                    busy_o
);

    localparam int IDW = $clog2(NREQ);
    localparam int IW1 = IDW + 1;
    localparam int TW  = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0]  T_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [IDW-1:0] ID_LAST = IDW'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [TW-1:0]  timer;

    logic           grant_any;
    logic [IDW-1:0] grant_id;
    logic [IDW-1:0] cand;
    logic [IW1-1:0] sum;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic [FW-1:0]  sel_fct;

    // Search ptr, ptr+1, ... wrapping at NREQ; the first asserted valid wins.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        cand      = '0;
        sum       = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr} + IW1'(i);
            if (sum >= IW1'(NREQ)) begin
                sum = sum - IW1'(NREQ);
            end
            cand = sum[IDW-1:0];
            if (!grant_any && req_valid_i[cand]) begin
                grant_any = 1'b1;
                grant_id  = cand;
            end
        end
    end

    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_fct = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == IDW'(i)) begin
                sel_a   = req_a_i[i*W +: W];
                sel_b   = req_b_i[i*W +: W];
                sel_fct = req_fct_i[i*FW +: FW];
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (state == S_IDLE && grant_any) begin
            req_ready_o[grant_id] = 1'b1;
        end
    end

    assign busy_o = (state != S_IDLE);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state         <= S_IDLE;
            ptr           <= '0;
            timer         <= '0;
            calc_start_o  <= 1'b0;
            calc_abort_o  <= 1'b0;
            calc_a_o      <= '0;
            calc_b_o      <= '0;
            calc_fct_o    <= '0;
            resp_valid_o  <= 1'b0;
            resp_id_o     <= '0;
            resp_s_o      <= '0;
            resp_signal_o <= 1'b0;
            resp_err_o    <= 1'b0;
        end else begin
            calc_start_o <= 1'b0;
            calc_abort_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        calc_a_o     <= sel_a;
                        calc_b_o     <= sel_b;
                        calc_fct_o   <= sel_fct;
                        resp_id_o    <= grant_id;
                        calc_start_o <= 1'b1;
                        state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // A completion in the final watchdog cycle still counts as success.
                    if (calc_done_i) begin
                        resp_s_o      <= calc_s_i;
                        resp_signal_o <= calc_signal_i;
                        resp_err_o    <= 1'b0;
                        resp_valid_o  <= 1'b1;
                        state         <= S_RESP;
                    end else if (timer == T_LAST) begin
                        resp_s_o      <= '0;
                        resp_signal_o <= 1'b0;
                        resp_err_o    <= 1'b1;
                        resp_valid_o  <= 1'b1;
                        calc_abort_o  <= 1'b1;
                        state         <= S_RESP;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_o <= 1'b0;
                        ptr          <= (resp_id_o == ID_LAST) ? '0 : resp_id_o + IDW'(1);
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_arbiter.sv
// tb/tb_calc_arbiter.sv - self-checking bench for calc_arbiter
// A job-age reference model is compared every cycle; directed scenarios add literal checks.
module tb_calc_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int FW   = 2;
    localparam int TO   = 16;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    logic rst;
    logic [NREQ-1:0]    vld;
    logic [NREQ*W-1:0]  req_a;
    logic [NREQ*W-1:0]  req_b;
    logic [NREQ*FW-1:0] req_fct;
    logic [NREQ-1:0]    req_ready;
    logic               calc_start;
    logic [W-1:0]       calc_a;
    logic [W-1:0]       calc_b;
    logic [FW-1:0]      calc_fct;
    logic               calc_abort;
    logic               calc_done;
    logic [W-1:0]       calc_s;
    logic               calc_signal;
    logic               resp_valid;
    logic               resp_rdy;
    logic [IDW-1:0]     resp_id;
    logic [W-1:0]       resp_s;
    logic               resp_signal;
    logic               resp_err;
    logic               busy;

    logic [W-1:0]  a_arr [NREQ];
    logic [W-1:0]  b_arr [NREQ];
    logic [FW-1:0] f_arr [NREQ];

    int  core_delay = -1;
    bit  man_done   = 1'b0;
    bit  keep_req   = 1'b0;
    bit  cmp_en     = 1'b0;
    int  n_pass     = 0;
    int  n_tot      = 0;
    int  n_start    = 0;
    int  n_abort    = 0;
    int  start_cyc  = 0;
    int  cyc        = 0;

    // Reference model: job age counts cycles since accept (1 = start, 2.. = waiting).
    int          m_age  = -1;
    int          m_ptr  = 0;
    int          m_id   = 0;
    bit          m_resp = 1'b0;
    bit          m_abort = 1'b0;
    bit          m_sig  = 1'b0;
    bit          m_err  = 1'b0;
    logic [W-1:0]  m_ca = '0;
    logic [W-1:0]  m_cb = '0;
    logic [W-1:0]  m_s  = '0;
    logic [FW-1:0] m_cf = '0;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            req_a[k*W +: W]     = a_arr[k];
            req_b[k*W +: W]     = b_arr[k];
            req_fct[k*FW +: FW] = f_arr[k];
        end
    end

    calc_arbiter #(.NREQ(NREQ), .W(W), .FW(FW), .TIMEOUT_CYC(TO)) dut (
        .clock_i       (clk),
        .reset_i       (rst),
        .req_valid_i   (vld),
        .req_a_i       (req_a),
        .req_b_i       (req_b),
        .req_fct_i     (req_fct),
        .req_ready_o   (req_ready),
        .calc_start_o  (calc_start),
        .calc_a_o      (calc_a),
        .calc_b_o      (calc_b),
        .calc_fct_o    (calc_fct),
        .calc_abort_o  (calc_abort),
        .calc_done_i   (calc_done),
        .calc_s_i      (calc_s),
        .calc_signal_i (calc_signal),
        .resp_valid_o  (resp_valid),
        .resp_ready_i  (resp_rdy),
        .resp_id_o     (resp_id),
        .resp_s_o      (resp_s),
        .resp_signal_o (resp_signal),
        .resp_err_o    (resp_err),
        .busy_o        (busy)
    );

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        int c;
        for (int k = 0; k < NREQ; k++) begin
            c = (p + k) % NREQ;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge clk) begin
        int g;
        cyc++;
        if (rst) begin
            m_age = -1; m_resp = 1'b0; m_ptr = 0; m_id = 0; m_abort = 1'b0;
            m_ca = '0; m_cb = '0; m_cf = '0; m_s = '0; m_sig = 1'b0; m_err = 1'b0;
        end else begin
            m_abort = 1'b0;
            if (m_resp) begin
                if (resp_rdy) begin
                    m_resp = 1'b0;
                    m_ptr  = (m_id + 1) % NREQ;
                end
            end else if (m_age < 0) begin
                g = pick(vld, m_ptr);
                if (g >= 0) begin
                    m_age = 1; m_id = g;
                    m_ca = a_arr[g]; m_cb = b_arr[g]; m_cf = f_arr[g];
                end
            end else if (m_age == 1) begin
                m_age = 2;
            end else if (calc_done) begin
                m_resp = 1'b1; m_s = calc_s; m_sig = calc_signal; m_err = 1'b0; m_age = -1;
            end else if (m_age - 2 == TO - 1) begin
                m_resp = 1'b1; m_s = '0; m_sig = 1'b0; m_err = 1'b1; m_abort = 1'b1; m_age = -1;
            end else begin
                m_age++;
            end
        end
    end

    always @(negedge clk) begin
        int g;
        int er;
        if (calc_start) begin n_start++; start_cyc = cyc; end
        if (calc_abort) n_abort++;
        if (cmp_en) begin
            er = 0;
            if (m_age < 0 && !m_resp) begin
                g = pick(vld, m_ptr);
                if (g >= 0) er = 1 << g;
            end
            chk("req_ready", int'(req_ready), er);
            chk("calc_start", int'(calc_start), int'(m_age == 1));
            chk("calc_abort", int'(calc_abort), int'(m_abort));
            chk("resp_valid", int'(resp_valid), int'(m_resp));
            chk("busy", int'(busy), int'(m_age >= 1 || m_resp));
            chk("calc_a", int'(calc_a), int'(m_ca));
            chk("calc_b", int'(calc_b), int'(m_cb));
            chk("calc_fct", int'(calc_fct), int'(m_cf));
            if (m_resp) begin
                chk("resp_id", int'(resp_id), m_id);
                chk("resp_s", int'(resp_s), int'(m_s));
                chk("resp_signal", int'(resp_signal), int'(m_sig));
                chk("resp_err", int'(resp_err), int'(m_err));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (m_age == 1 && !keep_req) vld[m_id] = 1'b0;
        calc_done = man_done || (core_delay >= 0 && m_age == core_delay + 1);
    endtask

    task automatic wait_resp(input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (resp_valid) break;
        end
        chk("resp_seen", int'(resp_valid), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s0;
        int a0;
        int ids [$];
        int exp_order [6];
        exp_order = '{0, 1, 2, 3, 0, 1};

        rst = 1'b1; vld = '0; resp_rdy = 1'b1;
        calc_done = 1'b0; calc_s = '0; calc_signal = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            a_arr[k] = W'(8'h10 + k); b_arr[k] = W'(8'h20 + k); f_arr[k] = FW'(k);
        end
        tick(); tick();
        cmp_en = 1'b1;
        rst = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_resp_valid", int'(resp_valid), 0);
        chk("rst_calc_a", int'(calc_a), 0);
        chk("rst_req_ready", int'(req_ready), 0);

        // Client 2, core completes two cycles after start
        a_arr[2] = 8'd5; b_arr[2] = 8'd3; f_arr[2] = 2'd0;
        core_delay = 2; calc_s = 8'd8; calc_signal = 1'b0;
        s0 = n_start;
        vld = 4'b0100;
        wait_resp(20);
        chk("t1_id", int'(resp_id), 2);
        chk("t1_s", int'(resp_s), 8);
        chk("t1_err", int'(resp_err), 0);
        chk("t1_calc_a", int'(calc_a), 5);
        chk("t1_starts", n_start - s0, 1);
        chk("t1_latency", cyc - start_cyc, 3);
        tick();

        // All clients requesting continuously from reset
        rst = 1'b1; vld = 4'b1111; keep_req = 1'b1; core_delay = 1; calc_s = 8'h10;
        tick(); tick();
        rst = 1'b0;
        for (int j = 0; j < 6; j++) begin
            wait_resp(20);
            ids.push_back(int'(resp_id));
            if (j == 5) vld = '0;
        end
        for (int j = 0; j < 6; j++) chk("t2_order", ids[j], exp_order[j]);
        keep_req = 1'b0;
        tick();

        // Core never completes: watchdog abort
        core_delay = -1; a0 = n_abort;
        vld = 4'b0010;
        wait_resp(40);
        chk("t3_err", int'(resp_err), 1);
        chk("t3_s", int'(resp_s), 0);
        chk("t3_abort", int'(calc_abort), 1);
        chk("t3_resp_cycle", cyc - start_cyc, TO + 1);
        tick();
        chk("t3_abort_count", n_abort - a0, 1);
        tick();

        // Response back-pressure with another client waiting
        resp_rdy = 1'b0; core_delay = 1; calc_s = 8'h33; calc_signal = 1'b1;
        vld = 4'b1000;
        wait_resp(20);
        vld[0] = 1'b1;
        s0 = n_start;
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("t4_ready", int'(req_ready), 0);
            chk("t4_s", int'(resp_s), 8'h33);
            chk("t4_valid", int'(resp_valid), 1);
        end
        chk("t4_starts", n_start - s0, 0);
        resp_rdy = 1'b1;
        wait_resp(20);
        chk("t4_next_id", int'(resp_id), 0);
        tick();

        // Done in the final watchdog cycle wins
        core_delay = TO; calc_s = 8'h7F; calc_signal = 1'b0; a0 = n_abort;
        vld = 4'b0001;
        wait_resp(40);
        chk("t6_err", int'(resp_err), 0);
        chk("t6_s", int'(resp_s), 8'h7F);
        chk("t6_resp_cycle", cyc - start_cyc, TO + 1);
        tick(); tick();
        chk("t6_no_abort", n_abort - a0, 0);

        // Reset during WAIT drops the job and the round-robin pointer
        core_delay = -1;
        vld = 4'b0100;
        for (int j = 0; j < 10; j++) begin
            tick();
            if (m_age == 3) break;
        end
        chk("t5_in_wait", int'(busy), 1);
        rst = 1'b1;
        tick();
        chk("t5_busy", int'(busy), 0);
        chk("t5_calc_a", int'(calc_a), 0);
        chk("t5_resp_valid", int'(resp_valid), 0);
        chk("t5_start", int'(calc_start), 0);
        chk("t5_abort", int'(calc_abort), 0);
        rst = 1'b0; man_done = 1'b1;
        tick();
        man_done = 1'b0;
        tick(); tick();
        chk("t5_late_done", int'(resp_valid), 0);
        core_delay = 1; calc_s = 8'h44;
        vld = 4'b1111;
        wait_resp(20);
        chk("t5_grant0", int'(resp_id), 0);
        vld = '0;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
